// File: rtl/pointwise_lane_packer_pkg.sv
// Shared parameters and types for the pointwise lane packer.
// Defaults match the pointwise multiplier instance (LOGQ and lane count).
package pointwise_lane_packer_pkg;

    localparam int NTT_LOGQ   = 19;
    localparam int NTT_LANES  = 8;
    localparam int LANE_CNT_W = $clog2(NTT_LANES);

    // EMPTY: no pair buffered in the fill register; FILL: partial vector held.
    typedef enum logic {
        ST_EMPTY,
        ST_FILL
    } pk_state_e;

endpackage

// File: rtl/pointwise_lane_packer.sv
// Pointwise lane packer: packs D (a,b) coefficient pairs into lane-ordered
// D*N-bit operand vectors presented from a registered valid/ready slot.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input pair handshake
//   in_a, in_b [N]            coefficient pair
//   in_last                   closes the current vector early
//   out_valid/out_ready       output vector handshake
//   out_a, out_b [D*N]        lane k at bits [(k+1)*N-1:k*N], lane 0 first
//   out_mask [D]              bit k set when lane k holds real data
//   out_last                  vector was closed by in_last
module pointwise_lane_packer
    import pointwise_lane_packer_pkg::*;
#(
    parameter int N = NTT_LOGQ,
    parameter int D = NTT_LANES
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D*N-1:0] out_a,
    output logic [D*N-1:0] out_b,
    output logic [D-1:0]   out_mask,
    output logic           out_last
);

    localparam int CW = $clog2(D);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST_LANE = cnt_t'(D - 1);

    pk_state_e      state_q, state_d;
    cnt_t           lane_cnt_q, lane_cnt_d;
    logic [D*N-1:0] fill_a_q, fill_a_d;
    logic [D*N-1:0] fill_b_q, fill_b_d;
    logic [D-1:0]   fill_m_q, fill_m_d;
    logic           out_valid_q, out_valid_d;
    logic [D*N-1:0] out_a_q, out_a_d;
    logic [D*N-1:0] out_b_q, out_b_d;
    logic [D-1:0]   out_m_q, out_m_d;
    logic           out_last_q, out_last_d;

    logic beat;
    logic done;

    // Ready depends only on the slot, so a consume and a completing beat
    // may share a cycle and the slot reloads without a bubble.
    assign in_ready = ~rst & (~out_valid_q | out_ready);
    assign beat     = in_valid & in_ready;
    assign done     = beat & (in_last | (lane_cnt_q == LAST_LANE));

    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        fill_a_d    = fill_a_q;
        fill_b_d    = fill_b_q;
        fill_m_d    = fill_m_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_m_d     = out_m_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (beat) begin
            fill_a_d[lane_cnt_q*N +: N] = in_a;
            fill_b_d[lane_cnt_q*N +: N] = in_b;
            fill_m_d[lane_cnt_q]        = 1'b1;
            lane_cnt_d                  = lane_cnt_q + 1'b1;
            state_d                     = ST_FILL;
        end

        // Unused lanes are already zero because the fill clears on
        // every completion; the slot takes the merged fill as-is.
        if (done) begin
            out_a_d     = fill_a_d;
            out_b_d     = fill_b_d;
            out_m_d     = fill_m_d;
            out_last_d  = in_last;
            out_valid_d = 1'b1;
            fill_a_d    = '0;
            fill_b_d    = '0;
            fill_m_d    = '0;
            lane_cnt_d  = '0;
            state_d     = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            lane_cnt_q  <= '0;
            fill_a_q    <= '0;
            fill_b_q    <= '0;
            fill_m_q    <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_m_q     <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            fill_a_q    <= fill_a_d;
            fill_b_q    <= fill_b_d;
            fill_m_q    <= fill_m_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_m_q     <= out_m_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_mask  = out_m_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_pointwise_lane_packer.sv
// Self-checking bench for pointwise_lane_packer.
// Expected vectors are queued at stimulus time and compared as they emerge.
module tb_pointwise_lane_packer;

    localparam int N = 19;
    localparam int D = 8;

    typedef struct packed {
        logic [D*N-1:0] a;
        logic [D*N-1:0] b;
        logic [D-1:0]   m;
        logic           l;
    } vec_t;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [D*N-1:0] out_a;
    logic [D*N-1:0] out_b;
    logic [D-1:0]   out_mask;
    logic           out_last;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stalls = 0;

    vec_t exp_q[$];
    vec_t obs_q[$];
    int   obs_c[$];

    logic [D*N-1:0] tb_a;
    logic [D*N-1:0] tb_b;
    logic [D-1:0]   tb_m;
    int             tb_cnt;

    pointwise_lane_packer #(.N(N), .D(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_mask  (out_mask),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output handshake, well away from the active edge.
    always @(negedge clk) begin
        #3;
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back({out_a, out_b, out_mask, out_last});
            obs_c.push_back(cyc);
        end
    end

    task automatic model_clear();
        tb_a = '0;
        tb_b = '0;
        tb_m = '0;
        tb_cnt = 0;
    endtask

    task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic last);
        tb_a[tb_cnt*N +: N] = a;
        tb_b[tb_cnt*N +: N] = b;
        tb_m[tb_cnt] = 1'b1;
        if (last || tb_cnt == D - 1) begin
            exp_q.push_back({tb_a, tb_b, tb_m, last});
            model_clear();
        end else begin
            tb_cnt++;
        end
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        #1;
        while (!in_ready && n < 50) begin
            stalls++;
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end else begin
            accept(a, b, last);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        model_clear();
        exp_q.delete();
    endtask

    task automatic wait_obs(input int n);
        int c = 0;
        while (obs_q.size() < n && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (obs_q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL wait_obs: got %0d vectors, required %0d",
                     obs_q.size(), n);
        end
    endtask

    function automatic vec_t pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    function automatic vec_t pop_obs(output int c);
        c = -1;
        if (obs_q.size() == 0) return 'x;
        c = obs_c.pop_front();
        return obs_q.pop_front();
    endfunction

    task automatic test_reset();
        logic [2*D*N+D+1:0] outs;
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 19'h1;
        in_b = 19'h2;
        in_last = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if ({in_ready, out_valid} !== 2'b00) begin
                fails++;
                $display("FAIL reset_hold: in_ready=%0b out_valid=%0b required 0 0",
                         in_ready, out_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        model_clear();
        #1;
        outs = {out_valid, out_a, out_b, out_mask, out_last};
        tests++;
        if (in_ready !== 1'b1 || outs !== '0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%0b outs=%h required 1 and 0",
                     in_ready, outs);
        end
        @(negedge clk);
    endtask

    task automatic test_full();
        vec_t e;
        vec_t o;
        int c;
        int bad = 0;
        out_ready = 1'b1;
        for (int k = 0; k < D; k++)
            send(N'(k + 1), N'(100 + k), k == D - 1);
        #1;
        for (int k = 0; k < D; k++)
            if (out_a[k*N +: N] !== N'(k + 1) || out_b[k*N +: N] !== N'(100 + k))
                bad++;
        tests++;
        if (out_valid !== 1'b1 || bad != 0 || out_mask !== 8'hFF
            || out_last !== 1'b1) begin
            fails++;
            $display("FAIL full_latency: valid=%0b bad_lanes=%0d mask=%h last=%0b required 1 0 ff 1",
                     out_valid, bad, out_mask, out_last);
        end
        wait_obs(1);
        e = pop_exp();
        o = pop_obs(c);
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL full_vec: got %h required %h", o, e);
        end
    endtask

    task automatic test_stream();
        vec_t e;
        vec_t o;
        int c1;
        int c2;
        out_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 2 * D; i++)
            send(N'(200 + i), N'(300 + i), i == 2 * D - 1);
        tests++;
        if (stalls !== 0) begin
            fails++;
            $display("FAIL stream_ready: stall cycles=%0d required 0", stalls);
        end
        wait_obs(2);
        e = pop_exp();
        o = pop_obs(c1);
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL stream_vec0: got %h required %h", o, e);
        end
        e = pop_exp();
        o = pop_obs(c2);
        tests++;
        if (o !== e || o.a[N-1:0] !== N'(208)) begin
            fails++;
            $display("FAIL stream_vec1: got %h required %h", o, e);
        end
        tests++;
        if (c2 - c1 !== 8) begin
            fails++;
            $display("FAIL stream_spacing: got %0d cycles required 8", c2 - c1);
        end
    endtask

    task automatic test_short_tail();
        vec_t e;
        vec_t o;
        int c;
        out_ready = 1'b1;
        send(19'd7, 19'd1, 1'b0);
        send(19'd8, 19'd2, 1'b0);
        send(19'd9, 19'd3, 1'b1);
        wait_obs(1);
        e = pop_exp();
        o = pop_obs(c);
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL tail_vec: got %h required %h", o, e);
        end
        tests++;
        if (o.m !== 8'h07 || o.l !== 1'b1 || o.a[D*N-1:3*N] !== '0
            || o.b[D*N-1:3*N] !== '0) begin
            fails++;
            $display("FAIL tail_fields: mask=%h last=%0b required 07 1", o.m, o.l);
        end
    endtask

    task automatic test_backpressure();
        vec_t e;
        vec_t o;
        int c;
        logic [2*D*N+D:0] snap;
        out_ready = 1'b0;
        for (int k = 0; k < D; k++)
            send(N'(20 + k), N'(40 + k), k == D - 1);
        in_valid = 1'b1;
        in_a = 19'd50;
        in_b = 19'd60;
        in_last = 1'b0;
        #1;
        snap = {out_a, out_b, out_mask, out_last};
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1
                || {out_a, out_b, out_mask, out_last} !== snap) begin
                fails++;
                $display("FAIL bp_hold: cycle %0d in_ready=%0b valid=%0b stable=%0b required 0 1 1",
                         i, in_ready, out_valid,
                         {out_a, out_b, out_mask, out_last} === snap);
            end
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: in_ready=%0b required 1", in_ready);
        end else begin
            accept(19'd50, 19'd60, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k < D; k++)
            send(N'(50 + k), N'(60 + k), k == D - 1);
        wait_obs(2);
        e = pop_exp();
        o = pop_obs(c);
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL bp_vec0: got %h required %h", o, e);
        end
        e = pop_exp();
        o = pop_obs(c);
        tests++;
        if (o !== e || o.a[N-1:0] !== 19'd50) begin
            fails++;
            $display("FAIL bp_vec1: got %h required %h", o, e);
        end
    endtask

    task automatic test_mid_reset();
        vec_t e;
        vec_t o;
        int c;
        int bad = 0;
        out_ready = 1'b0;
        send(19'd1, 19'd1, 1'b0);
        send(19'd2, 19'd2, 1'b1);
        do_reset(1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++)
            send(N'(k + 11), N'(k + 21), 1'b0);
        do_reset(1);
        for (int k = 0; k < D; k++)
            send(19'h7FFFF, N'(k), k == D - 1);
        wait_obs(1);
        repeat (4) @(negedge clk);
        tests++;
        if (obs_q.size() !== 1) begin
            fails++;
            $display("FAIL mid_reset_count: got %0d vectors required 1", obs_q.size());
        end
        e = pop_exp();
        o = pop_obs(c);
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL mid_reset_vec: got %h required %h", o, e);
        end
        for (int k = 0; k < D; k++)
            if (o.a[k*N +: N] !== 19'h7FFFF) bad++;
        tests++;
        if (bad != 0 || o.m !== 8'hFF) begin
            fails++;
            $display("FAIL mid_reset_fields: bad_lanes=%0d mask=%h required 0 ff",
                     bad, o.m);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        model_clear();
        test_reset();
        test_full();
        test_stream();
        test_short_tail();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
